// File: rtl/gather_hazard_ctrl_pkg.sv
// Shared definitions for the gather controllers and pipes: FSM encoding,
// default latencies and the update payload.
package gather_hazard_ctrl_pkg;

  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gather_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] dest;
  } update_t;

  // Cycles an address stays blocked after issue, counting the issue cycle.
  function automatic int unsigned haz_win_depth(input int unsigned rd_lat,
                                                input int unsigned pipe_depth);
    return rd_lat + pipe_depth + 1;
  endfunction

endpackage

// File: rtl/gather_hazard_ctrl_hazard_window.sv
// Shift-register CAM of recently issued addresses; flags a query that
// matches any valid entry.
module gather_hazard_ctrl_hazard_window #(
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              hit
);

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] addr [DEPTH];

  // Entries shift every cycle whether or not a push occurs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) addr[i] <= '0;
    end else begin
      vld[0]  <= push;
      addr[0] <= push_addr;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld[i]  <= vld[i-1];
        addr[i] <= addr[i-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld[i] && (addr[i] == query_addr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/gather_hazard_ctrl.sv
// Issue controller for a gather pipe: RAW hazard hold on in-flight
// destinations, URAM read issue, read-data alignment and phase sequencing.
module gather_hazard_ctrl #(
  parameter int unsigned PIPE_DEPTH = gather_hazard_ctrl_pkg::PIPE_DEPTH,
  parameter int unsigned RD_LAT     = gather_hazard_ctrl_pkg::RD_LAT,
  parameter int unsigned PAR_SIZE_W = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_value,
  input  logic [31:0]           in_dest,
  input  logic                  in_last,
  output logic                  uram_ren,
  output logic [PAR_SIZE_W-1:0] uram_raddr,
  output logic                  out_valid,
  output logic [31:0]           out_value,
  output logic [31:0]           out_dest,
  input  logic                  g_par_active,
  output logic                  busy,
  output logic                  done,
  output logic                  par_active_out,
  output logic [31:0]           issue_cnt,
  output logic [31:0]           stall_cnt
);

  import gather_hazard_ctrl_pkg::*;

  localparam int unsigned HAZ_WIN = haz_win_depth(RD_LAT, PIPE_DEPTH);
  // The issue cycle itself is slot 0 of the window; registers hold the rest.
  localparam int unsigned WIN_ENT = HAZ_WIN - 1;
  localparam int unsigned DRAIN_W = $clog2(HAZ_WIN + 1);
  localparam int unsigned CNT_W   = 32;

  gather_state_e         state;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  hazard;
  logic                  fire;
  logic [PAR_SIZE_W-1:0] dest_addr;
  logic [RD_LAT-1:0]     pipe_vld;
  update_t               pipe_data [RD_LAT];

  assign dest_addr  = in_dest[PAR_SIZE_W-1:0];
  assign in_ready   = (state == RUN) && !hazard;
  assign fire       = in_valid && in_ready;
  assign uram_ren   = fire;
  assign uram_raddr = dest_addr;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  gather_hazard_ctrl_hazard_window #(
    .DEPTH  (WIN_ENT),
    .ADDR_W (PAR_SIZE_W)
  ) u_hazard_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fire),
    .push_addr  (dest_addr),
    .query_addr (dest_addr),
    .hit        (hazard)
  );

  // Phase FSM, counters and sticky par_active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      issue_cnt      <= '0;
      stall_cnt      <= '0;
      par_active_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            issue_cnt      <= '0;
            stall_cnt      <= '0;
            par_active_out <= 1'b0;
          end
        end
        RUN: begin
          issue_cnt      <= issue_cnt + CNT_W'(fire);
          stall_cnt      <= stall_cnt + CNT_W'(in_valid && hazard);
          par_active_out <= par_active_out | g_par_active;
          if (fire && in_last) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(WIN_ENT);
          end
        end
        DRAIN: begin
          par_active_out <= par_active_out | g_par_active;
          drain_cnt      <= drain_cnt - DRAIN_W'(1);
          // Leave once the last issued address has aged out of the window.
          if (drain_cnt == DRAIN_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Update delayed RD_LAT cycles to line up with the URAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= fire;
      pipe_data[0] <= '{value: in_value, dest: in_dest};
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign out_valid = pipe_vld[RD_LAT-1];
  assign out_value = pipe_data[RD_LAT-1].value;
  assign out_dest  = pipe_data[RD_LAT-1].dest;

endmodule

// File: tb/tb_gather_hazard_ctrl.sv
// Directed bench for gather_hazard_ctrl at default latencies (HAZ_WIN=6).
module tb_gather_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [31:0] in_dest;
  logic        in_last;
  logic        uram_ren;
  logic [17:0] uram_raddr;
  logic        out_valid;
  logic [31:0] out_value;
  logic [31:0] out_dest;
  logic        g_par_active;
  logic        busy;
  logic        done;
  logic        par_active_out;
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  gather_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .in_dest        (in_dest),
    .in_last        (in_last),
    .uram_ren       (uram_ren),
    .uram_raddr     (uram_raddr),
    .out_valid      (out_valid),
    .out_value      (out_value),
    .out_dest       (out_dest),
    .g_par_active   (g_par_active),
    .busy           (busy),
    .done           (done),
    .par_active_out (par_active_out),
    .issue_cnt      (issue_cnt),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen; exp_n is the number of ticks required.
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] val, input logic l);
    in_valid = v;
    in_dest  = d;
    in_value = val;
    in_last  = l;
  endtask

  initial begin
    int n;
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; g_par_active = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_uram_ren",  32'(uram_ren), 32'd0);
    check("rst_issue_cnt", issue_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_par_active", 32'(par_active_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: four distinct dests back-to-back.
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    for (int d = 0; d < 4; d++) begin
      drive(1'b1, 32'(d), 32'(100 + d), d == 3);
      #1;
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_uram_ren", 32'(uram_ren), 32'd1);
      check("t1_raddr", 32'(uram_raddr), 32'(d));
      if (d >= 2) begin
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_dest", out_dest, 32'(d - 2));
      end
      tick();
    end
    drive(1'b1, 32'd50, 32'd0, 1'b0);
    #1;
    check("t1_drain_in_ready", 32'(in_ready), 32'd0);
    check("t1_drain_uram_ren", 32'(uram_ren), 32'd0);
    check("t1_out_dest2", out_dest, 32'd2);
    check("t1_out_value2", out_value, 32'd102);
    check("t1_done_early", 32'(done), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("t1_done_timing", 32'(done), 32'(k == 6));
      if (k == 2) check("t1_out_dest3", out_dest, 32'd3);
      if (k == 3) check("t1_out_valid_off", 32'(out_valid), 32'd0);
    end
    check("t1_issue_cnt", issue_cnt, 32'd4);
    check("t1_stall_cnt", stall_cnt, 32'd0);
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_done", 32'(done), 32'd0);

    // Test 2: same dest back-to-back stalls for five cycles.
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 32'd5, 32'd11, 1'b0);
    #1;
    check("t2_first_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'd5, 32'd12, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("t2_blocked", 32'(in_ready), 32'd0);
      tick();
    end
    #1;
    check("t2_reissue_ready", 32'(in_ready), 32'd1);
    check("t2_reissue_ren", 32'(uram_ren), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    wait_done("t2_done_lat", 5);
    check("t2_stall_cnt", stall_cnt, 32'd5);
    check("t2_issue_cnt", issue_cnt, 32'd2);
    tick();

    // Test 3: high dest bits ignored by the hazard compare.
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 32'h0004_0005, 32'd7, 1'b0);
    #1;
    check("t3_first_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h0000_0005, 32'd8, 1'b1);
    n = 0;
    while (n < 10) begin
      #1;
      if (in_ready) break;
      if (n == 1) begin
        check("t3_out_valid_a", 32'(out_valid), 32'd1);
        check("t3_out_dest_a", out_dest, 32'h0004_0005);
      end
      tick();
      n++;
    end
    check("t3_block_cycles", 32'(n), 32'd5);
    check("t3_raddr", 32'(uram_raddr), 32'd5);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("t3_out_dest_b", out_dest, 32'h0000_0005);
    check("t3_out_value_b", out_value, 32'd8);
    wait_done("t3_done_lat", 4);
    check("t3_stall_cnt", stall_cnt, 32'd5);

    // Test 4: sticky par_active_out; Test 6: in_valid in IDLE, start in RUN.
    tick();
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 32'd7, 32'd1, 1'b1);
    g_par_active = 1'b1;
    #1;
    check("t4_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    g_par_active = 1'b0;
    check("t4_par_drain", 32'(par_active_out), 32'd1);
    wait_done("t4_done_lat", 5);
    check("t4_par_done", 32'(par_active_out), 32'd1);
    tick();
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_par_idle", 32'(par_active_out), 32'd1);
    drive(1'b1, 32'd9, 32'd2, 1'b0);
    #1;
    check("t6_idle_ready", 32'(in_ready), 32'd0);
    check("t6_idle_ren", 32'(uram_ren), 32'd0);
    tick(); tick();
    check("t6_idle_issue", issue_cnt, 32'd1);
    check("t4_par_hold", 32'(par_active_out), 32'd1);
    start = 1'b1; tick();
    check("t4_par_cleared", 32'(par_active_out), 32'd0);
    check("t6_cnt_cleared", issue_cnt, 32'd0);
    #1;
    check("t6_run_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'd10, 32'd3, 1'b0);
    check("t6_start_ignored_1", issue_cnt, 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    drive(1'b1, 32'd11, 32'd4, 1'b1);
    check("t6_start_ignored_2", issue_cnt, 32'd2);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    check("t6_issue_cnt", issue_cnt, 32'd3);
    wait_done("t6_done_lat", 5);
    tick();

    // Test 5: reset during DRAIN abandons the phase and clears the window.
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b1, 32'd3, 32'd5, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("t5_pre_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_issue_cnt", issue_cnt, 32'd0);
    saw_done = done;
    start = 1'b1; tick(); start = 1'b0;
    saw_done = saw_done | done;
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_stall", stall_cnt, 32'd0);
    drive(1'b1, 32'd3, 32'd6, 1'b1);
    #1;
    check("t5_window_cleared", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    check("t5_no_stale_done", 32'(saw_done), 32'd0);
    wait_done("t5_done_lat", 5);
    check("t5_issue_cnt_new", issue_cnt, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
